// File: rtl/snake_grid_engine.sv
// Snake game core: occupancy bitmap, {x,y} body ring, apple placement and a registered cell query port.
// Optional build macro SNAKE_WRAP_EN: the head wraps across board edges instead of dying on walls.
module snake_grid_engine #(
  parameter int GRID_W    = 54,
  parameter int GRID_H    = 38,
  parameter int XW        = 6,
  parameter int YW        = 6,
  parameter int MAX_LEN   = 128,
  parameter int LW        = 8,
  parameter int INIT_X    = 2,
  parameter int INIT_Y    = 2,
  parameter int RETRY_MAX = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          tick,
  input  logic [3:0]    dir_req,
  input  logic [XW-1:0] rand_x,
  input  logic [YW-1:0] rand_y,
  input  logic [XW-1:0] qry_x,
  input  logic [YW-1:0] qry_y,
  output logic          qry_head,
  output logic          qry_body,
  output logic          qry_apple,
  output logic [LW-1:0] length,
  output logic          ate,
  output logic          running,
  output logic          game_over,
  output logic          board_full
);

  localparam int NCELL = GRID_W * GRID_H;
  localparam int IW    = $clog2(NCELL);
  localparam int PW    = $clog2(MAX_LEN);
  localparam int RW    = (RETRY_MAX > 1) ? $clog2(RETRY_MAX) : 1;

  localparam logic [XW-1:0] XMAX = XW'(GRID_W - 1);
  localparam logic [YW-1:0] YMAX = YW'(GRID_H - 1);
  localparam logic [XW-1:0] X0   = XW'(INIT_X);
  localparam logic [YW-1:0] Y0   = YW'(INIT_Y);
  localparam logic [LW-1:0] LMAX = LW'(MAX_LEN);

`ifdef SNAKE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam logic [3:0] D_UP = 4'b1000;
  localparam logic [3:0] D_DN = 4'b0100;
  localparam logic [3:0] D_LT = 4'b0010;
  localparam logic [3:0] D_RT = 4'b0001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLACE,
    S_RUN,
    S_STEP,
    S_DEAD
  } state_t;

  function automatic logic [IW-1:0] cell_idx(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return IW'(y) * IW'(GRID_W) + IW'(x);
  endfunction

  function automatic logic [3:0] rev_dir(input logic [3:0] d);
    return {d[2], d[3], d[0], d[1]};
  endfunction

  state_t          state_q;
  logic [NCELL-1:0] occ_q;
  logic [XW-1:0]   ring_x_q [MAX_LEN];
  logic [YW-1:0]   ring_y_q [MAX_LEN];
  logic [PW-1:0]   head_ptr_q;
  logic [XW-1:0]   head_x_q;
  logic [YW-1:0]   head_y_q;
  logic [LW-1:0]   len_q;
  logic [3:0]      dir_cur_q;
  logic [3:0]      dir_nxt_q;
  logic [XW-1:0]   apple_x_q;
  logic [YW-1:0]   apple_y_q;
  logic            apple_valid_q;
  logic [RW-1:0]   retry_q;
  logic            scan_q;
  logic [XW-1:0]   scan_x_q;
  logic [YW-1:0]   scan_y_q;
  logic            pend_q;
  logic            ate_q;
  logic            game_over_q;
  logic            board_full_q;
  logic            qh_q;
  logic            qb_q;
  logic            qa_q;

  // Next head cell and wall detection
  logic [XW-1:0] nxt_x_d;
  logic [YW-1:0] nxt_y_d;
  logic          wall_d;

  always_comb begin
    nxt_x_d = head_x_q;
    nxt_y_d = head_y_q;
    wall_d  = 1'b0;
    case (dir_nxt_q)
      D_UP: begin
        if (head_y_q == '0) begin
          wall_d  = 1'b1;
          nxt_y_d = YMAX;
        end else begin
          nxt_y_d = head_y_q - YW'(1);
        end
      end
      D_DN: begin
        if (head_y_q == YMAX) begin
          wall_d  = 1'b1;
          nxt_y_d = '0;
        end else begin
          nxt_y_d = head_y_q + YW'(1);
        end
      end
      D_LT: begin
        if (head_x_q == '0) begin
          wall_d  = 1'b1;
          nxt_x_d = XMAX;
        end else begin
          nxt_x_d = head_x_q - XW'(1);
        end
      end
      D_RT: begin
        if (head_x_q == XMAX) begin
          wall_d  = 1'b1;
          nxt_x_d = '0;
        end else begin
          nxt_x_d = head_x_q + XW'(1);
        end
      end
      default: ;
    endcase
  end

  logic [IW-1:0] nidx_d;
  logic [PW-1:0] tail_ptr_d;
  logic [PW-1:0] hp_nxt_d;
  logic [XW-1:0] tail_x_d;
  logic [YW-1:0] tail_y_d;
  logic          eat_d;
  logic          tail_hit_d;
  logic          self_d;
  logic          kill_d;

  assign nidx_d     = cell_idx(nxt_x_d, nxt_y_d);
  assign tail_ptr_d = head_ptr_q - PW'(len_q) + PW'(1);
  assign hp_nxt_d   = head_ptr_q + PW'(1);
  assign tail_x_d   = ring_x_q[tail_ptr_d];
  assign tail_y_d   = ring_y_q[tail_ptr_d];
  assign eat_d      = apple_valid_q && (nxt_x_d == apple_x_q) && (nxt_y_d == apple_y_q);
  assign tail_hit_d = (nxt_x_d == tail_x_d) && (nxt_y_d == tail_y_d);
  // The tail cell is only free to enter when the tail actually moves (no growth this step)
  assign self_d     = occ_q[nidx_d] && !(tail_hit_d && !eat_d);
  assign kill_d     = (wall_d && !WRAP) || self_d;

  // Direction request filtering; during STEP the reverse check uses the direction about to take effect
  logic [3:0] dir_ref_d;
  logic       dir_ok_d;

  assign dir_ref_d = (state_q == S_STEP) ? dir_nxt_q : dir_cur_q;
  assign dir_ok_d  = $onehot(dir_req) && (dir_req != rev_dir(dir_ref_d));

  // Apple placement candidate
  logic [XW-1:0] cand_x_d;
  logic [YW-1:0] cand_y_d;
  logic          cand_ok_d;
  logic          last_cell_d;

  assign cand_x_d    = scan_q ? scan_x_q : rand_x;
  assign cand_y_d    = scan_q ? scan_y_q : rand_y;
  assign cand_ok_d   = (cand_x_d <= XMAX) && (cand_y_d <= YMAX) && !occ_q[cell_idx(cand_x_d, cand_y_d)];
  assign last_cell_d = (scan_x_q == XMAX) && (scan_y_q == YMAX);

  logic start_ok_d;
  assign start_ok_d = start && ((state_q == S_IDLE) || (state_q == S_DEAD));

  always_ff @(posedge clk) begin
    ate_q <= 1'b0;
    if (!rst_n || start_ok_d) begin
      state_q       <= rst_n ? S_PLACE : S_IDLE;
      occ_q         <= '0;
      occ_q[cell_idx(X0, Y0)] <= 1'b1;
      ring_x_q[PW'(0)] <= X0;
      ring_y_q[PW'(0)] <= Y0;
      head_ptr_q    <= '0;
      head_x_q      <= X0;
      head_y_q      <= Y0;
      len_q         <= LW'(1);
      dir_cur_q     <= D_RT;
      dir_nxt_q     <= D_RT;
      apple_x_q     <= '0;
      apple_y_q     <= '0;
      apple_valid_q <= 1'b0;
      retry_q       <= '0;
      scan_q        <= (RETRY_MAX == 0);
      scan_x_q      <= '0;
      scan_y_q      <= '0;
      pend_q        <= 1'b0;
      game_over_q   <= 1'b0;
      board_full_q  <= 1'b0;
    end else begin
      if (dir_ok_d && ((state_q == S_PLACE) || (state_q == S_RUN) || (state_q == S_STEP)))
        dir_nxt_q <= dir_req;
      case (state_q)
        S_PLACE: begin
          if (tick) pend_q <= 1'b1;
          if (cand_ok_d) begin
            apple_x_q     <= cand_x_d;
            apple_y_q     <= cand_y_d;
            apple_valid_q <= 1'b1;
            state_q       <= S_RUN;
          end else if (scan_q) begin
            if (last_cell_d) begin
              state_q      <= S_DEAD;
              game_over_q  <= 1'b1;
              board_full_q <= 1'b1;
            end else if (scan_x_q == XMAX) begin
              scan_x_q <= '0;
              scan_y_q <= scan_y_q + YW'(1);
            end else begin
              scan_x_q <= scan_x_q + XW'(1);
            end
          end else begin
            retry_q <= retry_q + RW'(1);
            if (retry_q == RW'(RETRY_MAX - 1)) scan_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (tick || pend_q) begin
            pend_q  <= 1'b0;
            state_q <= S_STEP;
          end
        end
        S_STEP: begin
          if (tick) pend_q <= 1'b1;
          dir_cur_q <= dir_nxt_q;
          if (kill_d) begin
            state_q     <= S_DEAD;
            game_over_q <= 1'b1;
          end else begin
            head_x_q           <= nxt_x_d;
            head_y_q           <= nxt_y_d;
            head_ptr_q         <= hp_nxt_d;
            ring_x_q[hp_nxt_d] <= nxt_x_d;
            ring_y_q[hp_nxt_d] <= nxt_y_d;
            // Tail clear precedes head set so a tail-chasing head keeps its bit
            if (!eat_d || (len_q == LMAX)) occ_q[cell_idx(tail_x_d, tail_y_d)] <= 1'b0;
            occ_q[nidx_d] <= 1'b1;
            if (eat_d) begin
              ate_q         <= 1'b1;
              apple_valid_q <= 1'b0;
              if (len_q != LMAX) len_q <= len_q + LW'(1);
              retry_q       <= '0;
              scan_q        <= (RETRY_MAX == 0);
              scan_x_q      <= '0;
              scan_y_q      <= '0;
              state_q       <= S_PLACE;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        default: ;
      endcase
    end
  end

  logic q_inr_d;
  assign q_inr_d = (qry_x <= XMAX) && (qry_y <= YMAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      qh_q <= 1'b0;
      qb_q <= 1'b0;
      qa_q <= 1'b0;
    end else begin
      qh_q <= q_inr_d && (qry_x == head_x_q) && (qry_y == head_y_q);
      qb_q <= q_inr_d && occ_q[cell_idx(qry_x, qry_y)] && !((qry_x == head_x_q) && (qry_y == head_y_q));
      qa_q <= q_inr_d && apple_valid_q && (qry_x == apple_x_q) && (qry_y == apple_y_q);
    end
  end

  assign qry_head   = qh_q;
  assign qry_body   = qb_q;
  assign qry_apple  = qa_q;
  assign length     = len_q;
  assign ate        = ate_q;
  assign running    = (state_q == S_PLACE) || (state_q == S_RUN) || (state_q == S_STEP);
  assign game_over  = game_over_q;
  assign board_full = board_full_q;

endmodule

// File: tb/tb_snake_grid_engine.sv
// Directed bench for snake_grid_engine: movement table plus hand-written eat/collision/placement/reset sequences.
// Expectations for the wall case follow SNAKE_WRAP_EN when it is defined for the build.
module tb_snake_grid_engine;
  localparam int XW = 6;
  localparam int YW = 6;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          tick = 1'b0;
  logic [3:0]    dir_req = '0;
  logic [XW-1:0] rand_x = '0;
  logic [YW-1:0] rand_y = '0;
  logic [XW-1:0] qry_x = '0;
  logic [YW-1:0] qry_y = '0;
  logic          qry_head, qry_body, qry_apple, ate, running, game_over, board_full;
  logic [LW-1:0] length;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  snake_grid_engine #(
    .GRID_W(54),
    .GRID_H(38)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tick(tick), .dir_req(dir_req),
    .rand_x(rand_x), .rand_y(rand_y), .qry_x(qry_x), .qry_y(qry_y),
    .qry_head(qry_head), .qry_body(qry_body), .qry_apple(qry_apple),
    .length(length), .ate(ate), .running(running), .game_over(game_over),
    .board_full(board_full)
  );

  typedef struct {
    logic [3:0] dir;
    int         hx;
    int         hy;
    logic       go;
  } vec_t;

  vec_t tbl[8];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_cell(input string nm, input int x, input int y,
                          input logic eh, input logic eb, input logic ea);
    qry_x = XW'(x);
    qry_y = YW'(y);
    cyc();
    chk({nm, ".head"}, qry_head, eh);
    chk({nm, ".body"}, qry_body, eb);
    chk({nm, ".apple"}, qry_apple, ea);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; tick = 1'b0; dir_req = '0;
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  task automatic do_start(input int rx, input int ry);
    rand_x = XW'(rx); rand_y = YW'(ry);
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
  endtask

  // One direction-request cycle, one tick, then STEP and one spare cycle for PLACE after an eat
  task automatic step(input logic [3:0] d);
    dir_req = d; cyc(); dir_req = '0;
    tick = 1'b1; cyc(); tick = 1'b0;
    cyc(); cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{dir: 4'b0001, hx: 3, hy: 2, go: 1'b0};
    tbl[1] = '{dir: 4'b0100, hx: 3, hy: 3, go: 1'b0};
    tbl[2] = '{dir: 4'b1000, hx: 3, hy: 4, go: 1'b0};
    tbl[3] = '{dir: 4'b0010, hx: 2, hy: 4, go: 1'b0};
    tbl[4] = '{dir: 4'b0000, hx: 1, hy: 4, go: 1'b0};
    tbl[5] = '{dir: 4'b0011, hx: 0, hy: 4, go: 1'b0};
    tbl[6] = '{dir: 4'b1000, hx: 0, hy: 3, go: 1'b0};
`ifdef SNAKE_WRAP_EN
    tbl[7] = '{dir: 4'b0010, hx: 53, hy: 3, go: 1'b0};
`else
    tbl[7] = '{dir: 4'b0010, hx: 0, hy: 3, go: 1'b1};
`endif

    // Reset state and basic three-step run
    do_reset();
    chk("rst.length", length, 1);
    chk("rst.running", running, 0);
    chk("rst.game_over", game_over, 0);
    chk("rst.ate", ate, 0);
    chk("rst.board_full", board_full, 0);
    chk("rst.qry_head", qry_head, 0);
    chk_cell("rst.cell22", 2, 2, 1, 0, 0);
    do_start(10, 10);
    chk("t1.running", running, 1);
    for (int i = 0; i < 3; i++) step(4'b0000);
    chk_cell("t1.head52", 5, 2, 1, 0, 0);
    chk_cell("t1.old42", 4, 2, 0, 0, 0);
    chk_cell("t1.apple", 10, 10, 0, 0, 1);
    chk_cell("t1.oor_alias", 59, 1, 0, 0, 0);
    chk("t1.length", length, 1);
    chk("t1.game_over", game_over, 0);

    // Eat timing and re-placement, then direction filtering
    do_reset();
    do_start(3, 2);
    rand_x = 6'd20; rand_y = 6'd5;
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("t2.ate_T1", ate, 0);
    chk("t2.len_T1", length, 1);
    cyc();
    chk("t2.ate_T2", ate, 1);
    chk("t2.len_T2", length, 2);
    cyc();
    chk("t2.ate_T3", ate, 0);
    chk_cell("t2.head32", 3, 2, 1, 0, 0);
    chk_cell("t2.body22", 2, 2, 0, 1, 0);
    chk_cell("t2.newapple", 20, 5, 0, 0, 1);
    dir_req = 4'b0100; cyc();
    step(4'b0010);
    chk_cell("t3.head33", 3, 3, 1, 0, 0);
    chk_cell("t3.body32", 3, 2, 0, 1, 0);
    chk_cell("t3.tail22", 2, 2, 0, 0, 0);
    chk("t3.length", length, 2);

    // Movement table
    do_reset();
    do_start(50, 30);
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].dir);
      chk_cell($sformatf("tbl%0d", i), tbl[i].hx, tbl[i].hy, 1, 0, 0);
      chk($sformatf("tbl%0d.game_over", i), game_over, tbl[i].go);
    end

    // Right wall at x=53
    do_reset();
    do_start(10, 10);
    for (int i = 0; i < 51; i++) step(4'b0000);
    chk_cell("t4.head53", 53, 2, 1, 0, 0);
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("t4.go_T1", game_over, 0);
    cyc();
`ifdef SNAKE_WRAP_EN
    chk("t4.go_T2", game_over, 0);
    step(4'b0000); step(4'b0000);
    chk_cell("t4.wrapped", 2, 2, 1, 0, 0);
    chk("t4.running", running, 1);
`else
    chk("t4.go_T2", game_over, 1);
    step(4'b0000); step(4'b0000);
    chk_cell("t4.stuck", 53, 2, 1, 0, 0);
    chk("t4.go_sticky", game_over, 1);
    chk("t4.running", running, 0);
    do_start(10, 10);
    chk("t4.restart_go", game_over, 0);
    chk("t4.restart_len", length, 1);
    chk_cell("t4.restart_head", 2, 2, 1, 0, 0);
    chk_cell("t4.restart_old", 53, 2, 0, 0, 0);
`endif

    // Random candidates rejected, then row-major scan finds (0,0)
    do_reset();
    rand_x = 6'd2; rand_y = 6'd2;
    qry_x = '0; qry_y = '0;
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 9; i++) cyc();
    chk("t5.apple_c9", qry_apple, 0);
    cyc();
    chk("t5.apple_c10", qry_apple, 1);
    chk("t5.running", running, 1);

    // Grow to 4, tail chase is legal, grow to 5, then bite own body
    do_reset();
    do_start(3, 2);
    rand_x = 6'd4; rand_y = 6'd2; step(4'b0000);
    rand_x = 6'd5; step(4'b0000);
    rand_x = 6'd6; step(4'b0000);
    chk("t5.len4", length, 4);
    step(4'b0100);
    step(4'b0010);
    step(4'b1000);
    chk("t5.chase_go", game_over, 0);
    chk_cell("t5.chase_head", 4, 2, 1, 0, 0);
    step(4'b0001);
    chk("t5.chase2_go", game_over, 0);
    rand_x = 6'd40; rand_y = 6'd30;
    step(4'b0000);
    chk("t5.len5", length, 5);
    chk_cell("t5.head62", 6, 2, 1, 0, 0);
    step(4'b0100);
    step(4'b0010);
    chk("t5.pre_go", game_over, 0);
    step(4'b1000);
    chk("t5.bite_go", game_over, 1);
    chk("t5.bite_len", length, 5);
    chk_cell("t5.bite_head", 5, 3, 1, 0, 0);

    // Reset during PLACE
    do_reset();
    rand_x = 6'd2; rand_y = 6'd2;
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc();
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    chk("t6p.running", running, 0);
    chk("t6p.length", length, 1);
    chk_cell("t6p.head22", 2, 2, 1, 0, 0);

    // Reset during an eating STEP
    do_reset();
    do_start(3, 2);
    tick = 1'b1; cyc(); tick = 1'b0;
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    chk("t6s.length", length, 1);
    chk("t6s.ate", ate, 0);
    chk("t6s.game_over", game_over, 0);
    chk("t6s.running", running, 0);
    chk("t6s.qry_head", qry_head, 0);
    chk_cell("t6s.head22", 2, 2, 1, 0, 0);
    chk_cell("t6s.cell32", 3, 2, 0, 0, 0);
    chk("t6s.board_full", board_full, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
